fma_load_sequencer: RTL
=======================

# fma_load_sequencer

Command-driven sequencer that feeds `fma_memory_buffer` from a single-port data-cache BRAM. Given a command (A base, B base, step count K, initial c), it reads `a`/`b` operands for all FMA lanes, per step, and writes them lane-by-lane into the buffer. It waits for the buffer's `abc_valid_out` pulse before starting the next step, then signals completion after K steps. It sits between the top-level controller and the buffer/BRAM pair and sequences chained dot products.

## Interface
- `FMA_COUNT`, default 2: lanes in the attached buffer.
- `WIDTH`, default 16: bits per operand.
- `ADDR_WIDTH`, default 10: BRAM address width.
- `LEN_WIDTH`, default 8: width of the step count.
- `BRAM_LATENCY`, default 2: cycles from `rd_addr_out` to `rd_data_in`, fixed, at least 1.

Ports:
- `clk_in`  in  1  single clock, all logic on rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  command strobe; accepted only when `ready_out`=1.
- `a_base_in`  in  ADDR_WIDTH  A-vector base address.
- `b_base_in`  in  ADDR_WIDTH  B-vector base address.
- `length_in`  in  LEN_WIDTH  step count K.
- `c_init_in`  in  WIDTH  c value loaded into every lane on step 0.
- `ready_out`  out  1  high in IDLE.
- `done_out`  out  1  one-cycle pulse when the command completes.
- `rd_en_out`  out  1  BRAM read strobe.
- `rd_addr_out`  out  ADDR_WIDTH  BRAM read address.
- `rd_data_in`  in  WIDTH  BRAM read data.
- `buf_abc_out`  out  FMA_COUNT*3*WIDTH  drives the buffer's `abc_in`, using the same packing (lane f at bits f*3W, a at offset 0, b at offset W, c at offset 2W).
- `buf_abc_valid_out`  out  FMA_COUNT*3  drives the buffer's `abc_valid_in`.
- `buf_abc_valid_in`  in  1  the buffer's `abc_valid_out`.

## Operation
- **States:** IDLE, ISSUE, DRAIN, WAIT_BUF.
- **IDLE**
  - `start_in` latches all command fields and clears step counter k.
  - K=0: no reads; `done_out` pulses the next cycle; stay in IDLE.
  - Otherwise go to ISSUE.
- **ISSUE** (2*FMA_COUNT cycles)
  - Issues reads back-to-back for lanes f = 0..FMA_COUNT-1, in order a then b.
  - Addresses: A = a_base + k*FMA_COUNT + f; B = b_base + k*FMA_COUNT + f, both modulo 2^ADDR_WIDTH (wrap-around allowed).
  - Each read pushes a tag {valid, is_b, lane} into a BRAM_LATENCY-deep shift register.
  - After the last read, go to DRAIN.
- **Return path**
  - Tagged a-data is held in a register.
  - On tagged b-data, the next cycle drives one registered write: only lane f's slot carries {c, b, a}, other slots are 0.
  - Lane f's valid bits are 3'b011, or 3'b111 with c = c_init when k=0.
  - All other valid bits are 0.
  - a and b are always presented in the same cycle; the buffer requires this.
- **DRAIN:** go to WAIT_BUF once the final lane write has been emitted.
- **WAIT_BUF**
  - Waits for `buf_abc_valid_in`.
  - On seeing it: if k=K-1, go to IDLE and pulse `done_out`; else k++ and go to ISSUE.
  - No buffer writes are issued until that pulse has been seen; the buffer discards writes made during and just before its WRITING cycle.
- `start_in` outside IDLE is ignored.

## Timing
- **Reset values:** `ready_out`=1; `done_out`, `rd_en_out`, `buf_abc_valid_out` = 0; `rd_addr_out`, `buf_abc_out` = 0; the tag pipe is cleared.
- **Reset mid-command:** abort and return to IDLE the next cycle; in-flight BRAM data is ignored.
- **Step cadence** (F=FMA_COUNT, L=BRAM_LATENCY), with ISSUE entered at cycle 0:
  - reads at cycles 0..2F-1;
  - write for lane f at cycle 2f+2+L;
  - last write at 2F+L;
  - buffer pulse expected at 2F+L+2;
  - next ISSUE one cycle after the pulse, giving a period of 2F+L+3 cycles (9 for defaults).
- **Completion:** `done_out` and `ready_out` rise in the cycle after the final buffer pulse; `ready_out` is low from the cycle after start until then.
- **Buffer-pulse filtering:** a `buf_abc_valid_in` arriving outside WAIT_BUF is ignored.

## Test plan
- **Basic command.** Defaults; a_base=0x010, b_base=0x040, K=1, c_init=0x0100.
  - Read addresses must be 0x010, 0x040, 0x011, 0x041.
  - Lane 0 write has valid bits 3'b111 and c=0x0100.
  - After the buffer pulse, `done_out` pulses; `ready_out` returns 1.
- **Multi-step.** K=3.
  - Step 1 reads 0x012, 0x042, 0x013, 0x043 with valid bits 3'b011.
  - Step period is 9 cycles.
  - Exactly 3 buffer pulses, then one `done_out`.
- **Address wrap.** a_base=0x3FF, K=2, ADDR_WIDTH=10.
  - A addresses must be 0x3FF, 0x000, 0x001, 0x002.
- **Zero length.** K=0: no `rd_en_out`; `done_out` one cycle after start.
- **Ignored start and reset.**
  - `start_in` pulsed mid-command has no effect.
  - `rst_in` asserted during DRAIN gives IDLE with all outputs zero; no write appears from in-flight data.
- **Stalled buffer.** Delay `buf_abc_valid_in` by 20 cycles in WAIT_BUF: no reads or writes occur until it arrives.

Source files
------------

// File: rtl/fma_load_sequencer.sv
// Command-driven operand loader: reads a/b pairs for every FMA lane from a
// single-port BRAM each step and writes them into the FMA memory buffer.
module fma_load_sequencer #(
    parameter int FMA_COUNT    = 2,
    parameter int WIDTH        = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int LEN_WIDTH    = 8,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic [ADDR_WIDTH-1:0]        a_base_in,
    input  logic [ADDR_WIDTH-1:0]        b_base_in,
    input  logic [LEN_WIDTH-1:0]         length_in,
    input  logic [WIDTH-1:0]             c_init_in,
    output logic                         ready_out,
    output logic                         done_out,
    output logic                         rd_en_out,
    output logic [ADDR_WIDTH-1:0]        rd_addr_out,
    input  logic [WIDTH-1:0]             rd_data_in,
    output logic [FMA_COUNT*3*WIDTH-1:0] buf_abc_out,
    output logic [FMA_COUNT*3-1:0]       buf_abc_valid_out,
    input  logic                         buf_abc_valid_in,
    output logic [1:0]                   dbg_state_out
);

    // Handshake: a command is taken on any cycle where start_in and ready_out are
    // both high; start_in while ready_out is low is dropped, never queued.

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_DRAIN    = 2'd2,
        S_WAIT_BUF = 2'd3
    } state_t;

    localparam int LANE_W = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;
    localparam int CNT_W  = $clog2(2 * FMA_COUNT);
    localparam int TAG_W  = LANE_W + 2;
    localparam int SLOT_W = 3 * WIDTH;
    localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(2 * FMA_COUNT - 1);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(FMA_COUNT - 1);

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]        a_base_q, b_base_q;
    logic [LEN_WIDTH-1:0]         len_q, k_q;
    logic [WIDTH-1:0]             c_q;
    logic [CNT_W-1:0]             issue_cnt_q;
    logic                         done_q;
    logic [TAG_W-1:0]             tag_pipe [BRAM_LATENCY];
    logic [WIDTH-1:0]             a_hold_q;
    logic [FMA_COUNT*3*WIDTH-1:0] abc_q;
    logic [FMA_COUNT*3-1:0]       abc_valid_q;
    logic                         last_wr_q;

    logic [LANE_W-1:0]     issue_lane;
    logic                  issue_is_b;
    logic [ADDR_WIDTH-1:0] step_off;
    logic                  last_step;
    logic [TAG_W-1:0]      tag_out;
    logic                  ret_valid, ret_is_b;
    logic [LANE_W-1:0]     ret_lane;

    assign issue_lane = LANE_W'(issue_cnt_q >> 1);
    assign issue_is_b = issue_cnt_q[0];
    // Address arithmetic is deliberately modulo 2^ADDR_WIDTH.
    assign step_off   = ADDR_WIDTH'(k_q) * ADDR_WIDTH'(FMA_COUNT) + ADDR_WIDTH'(issue_lane);
    assign last_step  = (k_q == len_q - LEN_WIDTH'(1));
    assign tag_out    = tag_pipe[BRAM_LATENCY-1];
    assign ret_valid  = tag_out[TAG_W-1];
    assign ret_is_b   = tag_out[TAG_W-2];
    assign ret_lane   = tag_out[LANE_W-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_in && length_in != '0) state_d = S_ISSUE;
            S_ISSUE:    if (issue_cnt_q == LAST_ISSUE) state_d = S_DRAIN;
            S_DRAIN:    if (last_wr_q) state_d = S_WAIT_BUF;
            S_WAIT_BUF: if (buf_abc_valid_in) state_d = last_step ? S_IDLE : S_ISSUE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_out     = (state_q == S_IDLE);
        rd_en_out     = (state_q == S_ISSUE);
        rd_addr_out   = '0;
        dbg_state_out = state_q;
        if (state_q == S_ISSUE) begin
            rd_addr_out = (issue_is_b ? b_base_q : a_base_q) + step_off;
        end
    end

    assign done_out          = done_q;
    assign buf_abc_out       = abc_q;
    assign buf_abc_valid_out = abc_valid_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_base_q    <= '0;
            b_base_q    <= '0;
            len_q       <= '0;
            c_q         <= '0;
            k_q         <= '0;
            issue_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        a_base_q    <= a_base_in;
                        b_base_q    <= b_base_in;
                        len_q       <= length_in;
                        c_q         <= c_init_in;
                        k_q         <= '0;
                        issue_cnt_q <= '0;
                        done_q      <= (length_in == '0);
                    end
                end
                S_ISSUE: begin
                    issue_cnt_q <= (issue_cnt_q == LAST_ISSUE) ? '0 : issue_cnt_q + CNT_W'(1);
                end
                S_WAIT_BUF: begin
                    if (buf_abc_valid_in) begin
                        if (last_step) begin
                            done_q <= 1'b1;
                        end else begin
                            k_q         <= k_q + LEN_WIDTH'(1);
                            issue_cnt_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Each read's identity travels alongside the BRAM latency so returning data can be routed.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BRAM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= {(state_q == S_ISSUE), issue_is_b, issue_lane};
            for (int i = 1; i < BRAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_hold_q    <= '0;
            abc_q       <= '0;
            abc_valid_q <= '0;
            last_wr_q   <= 1'b0;
        end else begin
            abc_q       <= '0;
            abc_valid_q <= '0;
            last_wr_q   <= 1'b0;
            if (ret_valid && !ret_is_b) a_hold_q <= rd_data_in;
            // a and b land together: the buffer rejects a lane write that splits them.
            if (ret_valid && ret_is_b) begin
                abc_q[int'(ret_lane)*SLOT_W +: WIDTH]           <= a_hold_q;
                abc_q[int'(ret_lane)*SLOT_W + WIDTH +: WIDTH]   <= rd_data_in;
                abc_q[int'(ret_lane)*SLOT_W + 2*WIDTH +: WIDTH] <= (k_q == '0) ? c_q : '0;
                abc_valid_q[int'(ret_lane)*3 +: 3]              <= (k_q == '0) ? 3'b111 : 3'b011;
                last_wr_q                                       <= (ret_lane == LAST_LANE);
            end
        end
    end

endmodule
